mem_access: RTL and testbench
=============================

# mem_access

Y86 memory stage placed between the execute/memory pipeline register and `mem_wb`. It decodes the M-stage instruction's memory operation and runs a multi-cycle request/ready transaction on the data-memory port. While a transaction is in flight it stalls upstream and presents a bubble to `mem_wb`. It then delivers `mem_icode/valE/valM/dstE/dstM` plus a status code for write-back.

## Interface
- `ADDR_LIMIT`, default 32'h0000_1000: addresses ≥ this value are invalid and flagged SADR.
- `TIMEOUT`, default 16: maximum REQ cycles before the access is abandoned with SADR.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `M_icode` in 4: M-stage icode.
- `M_stat` in 4: incoming status (1=AOK, 2=ADR, 3=INS, 4=HLT).
- `M_valE` in 32: ALU result.
- `M_valA` in 32: operand A.
- `M_dstE` in 4: destination E.
- `M_dstM` in 4: destination M.
- `dmem_ready` in 1: memory completes the access this cycle.
- `dmem_rdata` in 32: read data, valid with `dmem_ready`.
- `dmem_err` in 1: bus error, valid with `dmem_ready`.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: access address.
- `dmem_wdata` out 32: write data.
- `M_stall_o` out 1: hold M-stage inputs stable.
- `mem_icode` out 4: to `mem_wb`.
- `mem_valE` out 32: to `mem_wb`.
- `mem_valM` out 32: to `mem_wb`.
- `mem_dstE` out 4: to `mem_wb`.
- `mem_dstM` out 4: to `mem_wb`.
- `mem_stat` out 4: to `mem_wb`.

## Operation
- Decode:
  - Reads: MRMOVL(5), POPL(B), RET(9).
  - Writes: RMMOVL(4), PUSHL(A), CALL(8).
  - Address: `M_valA` for POPL and RET; `M_valE` for the others.
  - Write data: `M_valA`.
- A memory op is performed only when `M_stat`=AOK. Otherwise the instruction passes through untouched with its `M_stat`.
- Address check: if addr ≥ `ADDR_LIMIT`, no request is issued. The instruction passes in the same cycle with `mem_stat`=2 and `mem_dstM`=F. `mem_dstE` is passed unchanged.
- Bubble: `mem_icode`=1 (NOP), `mem_dstE`=`mem_dstM`=F, `mem_valE`=`mem_valM`=0, `mem_stat`=1.
- State IDLE:
  - Non-memory op: combinational pass-through. `mem_valM`=0, `M_stall_o`=0.
  - Valid memory op: output bubble, `M_stall_o`=1, next state REQ.
- State REQ:
  - Drive `dmem_req`=1, with `dmem_we/addr/wdata` held constant from the M-stage inputs. Output bubble, `M_stall_o`=1.
  - Timeout counter (5 bits) increments each REQ cycle.
  - On `dmem_ready`:
    - Capture `dmem_rdata` into `valM_q`, or 0 for writes.
    - Capture `err_q` = `dmem_err`.
    - Next state DONE.
  - Counter = `TIMEOUT`-1 without ready: `err_q`=1, `valM_q`=0, next state DONE. `dmem_req` drops in DONE.
- State DONE:
  - Output the instruction with `mem_valM`=`valM_q`.
  - `err_q`=1: `mem_stat`=2 and `mem_dstM`=F.
  - `M_stall_o`=0, so upstream advances at this edge. Clear the counter, next state IDLE.
- `M_stall_o` is combinational from state and decode. The upstream register uses it as a stall, not a bubble.
- `dmem_ready` outside REQ is ignored.

## Timing
- Reset (sync, `rst`=1 at posedge):
  - Clears: state→IDLE, `valM_q`=0, `err_q`=0, counter=0.
  - While `rst`=1, outputs are forced to bubble, `dmem_req`=0, `M_stall_o`=0.
  - Reset during REQ abandons the access. No completion is reported.
- Non-memory, bad-address and non-AOK instructions: 0-cycle latency; `mem_wb` captures them at the next edge.
- Memory op with ready on the first REQ cycle: output valid in cycle 2 (IDLE=0, REQ=1, DONE=2). Each extra REQ cycle adds 1.
- Maximum occupancy: 1 (IDLE) + `TIMEOUT` (REQ) + 1 (DONE) cycles.
- `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` are stable throughout REQ. `dmem_req` is never asserted outside REQ.
- Back-to-back memory ops: after DONE the next instruction enters IDLE and starts its own 3+ cycle sequence. There is no overlap.

## Test plan
- ADDL(6), `M_valE`=5, dstE=0 → same cycle `mem_icode`=6, `mem_valE`=5, `mem_dstE`=0, `mem_dstM`=F, `mem_stat`=1, `M_stall_o`=0, `dmem_req` never 1.
- MRMOVL, `M_valE`=0x100, memory ready on 3rd REQ cycle with rdata 0xDEADBEEF:
  - `dmem_req` high for exactly 3 cycles with `dmem_addr`=0x100 and `dmem_we`=0.
  - Next cycle: `mem_valM`=0xDEADBEEF, `mem_dstM`=`M_dstM`, `M_stall_o` low.
  - Bubbles shown to `mem_wb` in all earlier cycles.
- PUSHL, `M_valE`=0x1FC, `M_valA`=7, ready on 1st REQ cycle → `dmem_we`=1, `dmem_addr`=0x1FC, `dmem_wdata`=7; DONE with `mem_valM`=0, `mem_stat`=1.
- POPL, `M_valA`=0x2000 (≥ `ADDR_LIMIT`) → no request; same cycle `mem_stat`=2, `mem_dstM`=F.
- MRMOVL, `dmem_ready` never asserted → `dmem_req` high exactly 16 cycles, then DONE with `mem_stat`=2, `mem_valM`=0.
- RET, `dmem_err`=1 with ready → `mem_stat`=2.
- `rst` asserted in the 2nd REQ cycle → next cycle state IDLE, `dmem_req`=0, bubble outputs.

Source files
------------

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : Y86 memory stage; runs a request/ready data-memory transaction
//            while stalling upstream, then hands the result to mem_wb.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_stat,
    input  logic [31:0] M_valE,
    input  logic [31:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        M_stall_o,
    output logic [3:0]  mem_icode,
    output logic [31:0] mem_valE,
    output logic [31:0] mem_valM,
    output logic [3:0]  mem_dstE,
    output logic [3:0]  mem_dstM,
    output logic [3:0]  mem_stat
);

    localparam logic [3:0] c_i_nop    = 4'h1;
    localparam logic [3:0] c_i_rmmovl = 4'h4;
    localparam logic [3:0] c_i_mrmovl = 4'h5;
    localparam logic [3:0] c_i_call   = 4'h8;
    localparam logic [3:0] c_i_ret    = 4'h9;
    localparam logic [3:0] c_i_pushl  = 4'hA;
    localparam logic [3:0] c_i_popl   = 4'hB;
    localparam logic [3:0] c_stat_aok = 4'h1;
    localparam logic [3:0] c_stat_adr = 4'h2;
    localparam logic [3:0] c_reg_none = 4'hF;
    localparam logic [4:0] c_tmo_last = 5'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_valm;
    logic        r_err;
    logic [4:0]  r_cnt;

    logic        w_is_read;
    logic        w_is_write;
    logic        w_addr_from_a;
    logic [31:0] w_addr;
    logic        w_mem_aok;
    logic        w_addr_bad;
    logic        w_mem_go;

    always_comb begin
        w_is_read     = 1'b0;
        w_is_write    = 1'b0;
        w_addr_from_a = 1'b0;
        case (M_icode)
            c_i_mrmovl: w_is_read = 1'b1;
            c_i_popl,
            c_i_ret: begin
                w_is_read     = 1'b1;
                w_addr_from_a = 1'b1;
            end
            c_i_rmmovl,
            c_i_pushl,
            c_i_call:   w_is_write = 1'b1;
            default: ;
        endcase
    end

    assign w_addr     = w_addr_from_a ? M_valA : M_valE;
    assign w_mem_aok  = (w_is_read || w_is_write) && (M_stat == c_stat_aok);
    assign w_addr_bad = (w_addr >= ADDR_LIMIT);
    assign w_mem_go   = w_mem_aok && !w_addr_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_valm  <= 32'd0;
            r_err   <= 1'b0;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_st_req: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (dmem_ready) begin
                        r_valm <= w_is_write ? 32'd0 : dmem_rdata;
                        r_err  <= dmem_err;
                    end else if (r_cnt == c_tmo_last) begin
                        r_valm <= 32'd0;
                        r_err  <= 1'b1;
                    end
                end
                c_st_done: r_cnt <= 5'd0;
                default: ;
            endcase
        end
    end

    // Defaults describe the bubble presented to mem_wb; reset keeps them.
    always_comb begin
        w_state_next = r_state;
        mem_icode    = c_i_nop;
        mem_valE     = 32'd0;
        mem_valM     = 32'd0;
        mem_dstE     = c_reg_none;
        mem_dstM     = c_reg_none;
        mem_stat     = c_stat_aok;
        M_stall_o    = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = 32'd0;
        dmem_wdata   = 32'd0;
        if (rst) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_mem_go) begin
                        M_stall_o    = 1'b1;
                        w_state_next = c_st_req;
                    end else begin
                        mem_icode = M_icode;
                        mem_valE  = M_valE;
                        mem_dstE  = M_dstE;
                        mem_dstM  = (w_mem_aok && w_addr_bad) ? c_reg_none : M_dstM;
                        mem_stat  = (w_mem_aok && w_addr_bad) ? c_stat_adr : M_stat;
                    end
                end
                c_st_req: begin
                    M_stall_o  = 1'b1;
                    dmem_req   = 1'b1;
                    dmem_we    = w_is_write;
                    dmem_addr  = w_addr;
                    dmem_wdata = M_valA;
                    if (dmem_ready || (r_cnt == c_tmo_last)) begin
                        w_state_next = c_st_done;
                    end
                end
                c_st_done: begin
                    mem_icode    = M_icode;
                    mem_valE     = M_valE;
                    mem_valM     = r_valm;
                    mem_dstE     = M_dstE;
                    mem_dstM     = r_err ? c_reg_none : M_dstM;
                    mem_stat     = r_err ? c_stat_adr : M_stat;
                    w_state_next = c_st_idle;
                end
                default: w_state_next = c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Brief    : Scoreboard bench for mem_access: pass-through, reads, writes,
//            timeout, bus error, reset during a request, back-to-back ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam logic [3:0] c_none = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  M_icode = 4'h1;
    logic [3:0]  M_stat = 4'h1;
    logic [31:0] M_valE = 32'd0;
    logic [31:0] M_valA = 32'd0;
    logic [3:0]  M_dstE = 4'hF;
    logic [3:0]  M_dstM = 4'hF;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_err = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        M_stall_o;
    logic [3:0]  mem_icode;
    logic [31:0] mem_valE;
    logic [31:0] mem_valM;
    logic [3:0]  mem_dstE;
    logic [3:0]  mem_dstM;
    logic [3:0]  mem_stat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [81:0] sb[$];
    logic [64:0] sb_bus[$];
    logic [81:0] obs;

    always #5 clk = ~clk;

    mem_access #(.ADDR_LIMIT(32'h0000_1000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .M_icode(M_icode), .M_stat(M_stat), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .M_stall_o(M_stall_o),
        .mem_icode(mem_icode), .mem_valE(mem_valE), .mem_valM(mem_valM),
        .mem_dstE(mem_dstE), .mem_dstM(mem_dstM), .mem_stat(mem_stat)
    );

    assign obs = {mem_icode, mem_valE, mem_valM, mem_dstE, mem_dstM, mem_stat,
                  M_stall_o, dmem_req};

    function automatic logic [81:0] mk(input logic [3:0] ic, input logic [31:0] ve,
                                       input logic [31:0] vm, input logic [3:0] de,
                                       input logic [3:0] dm, input logic [3:0] st,
                                       input logic stall, input logic req);
        return {ic, ve, vm, de, dm, st, stall, req};
    endfunction

    task automatic drive(input logic [3:0] ic, input logic [3:0] st, input logic [31:0] ve,
                         input logic [31:0] va, input logic [3:0] de, input logic [3:0] dm);
        M_icode = ic; M_stat = st; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    endtask

    task automatic test_reset();
        logic [81:0] e;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            drive(4'h5, 4'h1, 32'h100, 32'h0, c_none, 4'h2);
            dmem_ready = 1'b1;
            sb.push_back(mk(4'h1, 32'd0, 32'd0, c_none, c_none, 4'h1, 1'b0, 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL reset cyc%0d: got %h want %h", c, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_passthrough();
        logic [3:0]  ic[4] = '{4'h6, 4'hB, 4'h5, 4'h5};
        logic [3:0]  st[4] = '{4'h1, 4'h1, 4'h3, 4'h1};
        logic [31:0] ve[4] = '{32'h5, 32'h2004, 32'h100, 32'h1000};
        logic [31:0] va[4] = '{32'h0, 32'h2000, 32'h0, 32'h0};
        logic [3:0]  de[4] = '{4'h0, 4'h4, c_none, c_none};
        logic [3:0]  dm[4] = '{c_none, 4'h3, 4'h2, 4'h6};
        logic [81:0] e;
        sb.push_back(mk(4'h6, 32'h5, 32'd0, 4'h0, c_none, 4'h1, 1'b0, 1'b0));
        sb.push_back(mk(4'hB, 32'h2004, 32'd0, 4'h4, c_none, 4'h2, 1'b0, 1'b0));
        sb.push_back(mk(4'h5, 32'h100, 32'd0, c_none, 4'h2, 4'h3, 1'b0, 1'b0));
        sb.push_back(mk(4'h5, 32'h1000, 32'd0, c_none, c_none, 4'h2, 1'b0, 1'b0));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            dmem_ready = 1'b1;
            drive(ic[c], st[c], ve[c], va[c], de[c], dm[c]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL passthrough case%0d: got %h want %h", c, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_mem_op(input string name, input logic [3:0] ic,
                               input logic [31:0] ve, input logic [31:0] va,
                               input logic [3:0] de, input logic [3:0] dm,
                               input int ready_at, input logic [31:0] rdata,
                               input logic err);
        int          n_req;
        logic        wr;
        logic        bad;
        logic [31:0] ad;
        logic [81:0] e;
        logic [64:0] b;
        n_req = (ready_at == 0) ? 16 : ready_at;
        wr    = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
        ad    = ((ic == 4'hB) || (ic == 4'h9)) ? va : ve;
        bad   = (ready_at == 0) || err;
        sb.push_back(mk(4'h1, 32'd0, 32'd0, c_none, c_none, 4'h1, 1'b1, 1'b0));
        for (int i = 0; i < n_req; i++) begin
            sb.push_back(mk(4'h1, 32'd0, 32'd0, c_none, c_none, 4'h1, 1'b1, 1'b1));
            sb_bus.push_back({wr, ad, va});
        end
        sb.push_back(mk(ic, ve, ((ready_at == 0) || wr) ? 32'd0 : rdata, de,
                        bad ? c_none : dm, bad ? 4'h2 : 4'h1, 1'b0, 1'b0));
        for (int c = 0; c <= n_req + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                rst = 1'b0;
                drive(ic, 4'h1, ve, va, de, dm);
            end
            // Ready is also pulsed in IDLE and DONE, where it must be ignored.
            dmem_ready = (c == 0) || (c == n_req + 1) || ((ready_at != 0) && (c == ready_at));
            dmem_rdata = (c == ready_at) ? rdata : 32'h5A5A_5A5A;
            dmem_err   = (c == ready_at) ? err : 1'b1;
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL %s cyc%0d: got %h want %h", name, c, obs, e);
            else n_pass++;
            if (e[0]) begin
                b = sb_bus.pop_front();
                n_checks++;
                if ({dmem_we, dmem_addr, dmem_wdata} !== b)
                    $display("FAIL %s bus cyc%0d: got %h want %h", name, c,
                             {dmem_we, dmem_addr, dmem_wdata}, b);
                else n_pass++;
            end
        end
        dmem_ready = 1'b0;
        dmem_err   = 1'b0;
    endtask

    task automatic test_reset_in_req();
        logic [81:0] e;
        logic [64:0] b;
        sb.push_back(mk(4'h1, 32'd0, 32'd0, c_none, c_none, 4'h1, 1'b1, 1'b0));
        sb.push_back(mk(4'h1, 32'd0, 32'd0, c_none, c_none, 4'h1, 1'b1, 1'b1));
        sb_bus.push_back({1'b0, 32'h200, 32'h0});
        for (int c = 0; c < 3; c++)
            sb.push_back(mk(4'h1, 32'd0, 32'd0, c_none, c_none, 4'h1, 1'b0, 1'b0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            rst = (c == 2);
            if (c == 0) drive(4'h5, 4'h1, 32'h200, 32'h0, c_none, 4'h1);
            if (c == 3) begin
                drive(4'h1, 4'h1, 32'h0, 32'h0, c_none, c_none);
                dmem_ready = 1'b1;
            end
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL rst_in_req cyc%0d: got %h want %h", c, obs, e);
            else n_pass++;
            if (e[0]) begin
                b = sb_bus.pop_front();
                n_checks++;
                if ({dmem_we, dmem_addr, dmem_wdata} !== b)
                    $display("FAIL rst_in_req bus cyc%0d: got %h want %h", c,
                             {dmem_we, dmem_addr, dmem_wdata}, b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        test_mem_op("b2b_popl", 4'hB, 32'h200, 32'h1FC, 4'h4, 4'h3, 2, 32'hCAFE_0001, 1'b0);
        test_mem_op("b2b_rmmovl", 4'h4, 32'h0FFC, 32'h55, c_none, c_none, 1, 32'h0, 1'b0);
        test_mem_op("b2b_mrmovl", 4'h5, 32'h0FFC, 32'h0, c_none, 4'h6, 1, 32'h1234_5678, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_passthrough();
        test_mem_op("mrmovl", 4'h5, 32'h100, 32'h0, c_none, 4'h2, 3, 32'hDEAD_BEEF, 1'b0);
        test_mem_op("pushl", 4'hA, 32'h1FC, 32'h7, 4'h4, c_none, 1, 32'h9999_9999, 1'b0);
        test_mem_op("timeout", 4'h5, 32'h300, 32'h0, c_none, 4'h6, 0, 32'h0, 1'b0);
        test_mem_op("ret_err", 4'h9, 32'h84, 32'h80, 4'h4, c_none, 1, 32'h1234, 1'b1);
        test_reset_in_req();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
